ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS32 pipeline. It consumes the ID/EX pipeline register outputs and computes:
- the GPR result, combinationally;
- the HI/LO result for multiply and divide;
- forwarded write controls for the EX/MEM register.

Division runs as a 32-iteration sequential divider, and the block raises a stall request to the pipeline controller until the quotient and remainder are ready.

## Interface
Parameters:
- None. Operation codes come from `defines.v`.

Ports (`clk` and `rst` first):
- `clk`  in  1  pipeline clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ALUop_i`  in  5  operation code from ID/EX (`ALU_*` constants).
- `oprand1_i`  in  32  operand 1; also the shift amount source, `[4:0]`.
- `oprand2_i`  in  32  operand 2; also the value to be shifted.
- `signed_i`  in  1  1 = signed semantics for SLT, MULT and DIV.
- `writeAddr_i`  in  5  destination GPR.
- `writeEnable_i`  in  1  GPR write enable.
- `writeHILO_i`  in  2  bit1 = write HI, bit0 = write LO.
- `hi_i`, `lo_i`  in  32 each  current HI/LO values, already forwarded upstream.
- `writeData_o`  out  32  GPR result.
- `writeAddr_o`, `writeEnable_o`, `writeHILO_o`  out  5/1/2  pass-through of the corresponding inputs.
- `hi_o`, `lo_o`  out  32 each  HI/LO result.
- `stallReq_o`  out  1  EX stall request; the controller sets `stall[3:0]` from it.

## Operation
- Reset: while `rst`=1, all outputs are 0 and the divider FSM is in IDLE.
- Combinational operations, with no added latency:
  - ADD/SUB: 32-bit wraparound; no overflow trap.
  - AND/OR/XOR/NOR: bitwise.
  - SLL/SRL/SRA: shift `oprand2_i` by `oprand1_i[4:0]`.
  - SLT: 1/0, signed or unsigned per `signed_i`.
  - MFHI/MFLO: `writeData_o` = `hi_i`/`lo_i`.
  - NOP: `writeData_o` = 0.
- MULT: 64-bit product of two 32-bit operands.
  - Signed or unsigned per `signed_i`.
  - `{hi_o, lo_o}` = product, available combinationally.
- For non-HI/LO operations, `hi_o`/`lo_o` are 0.
- DIV uses the `ex_divider` FSM with states IDLE, BUSY and DONE:
  - IDLE with `ALUop_i`=DIV and divisor ≠ 0: latch operand magnitudes (absolute values when signed), clear the iteration counter, go to BUSY.
  - IDLE with `ALUop_i`=DIV and divisor = 0: go to DONE with `lo_o`=32'hFFFFFFFF and `hi_o`=dividend.
  - BUSY: one restoring shift-subtract step per cycle; after the 32nd step, go to DONE.
  - DONE: for signed division, apply signs:
    - quotient sign = sign(op1) XOR sign(op2);
    - remainder sign = sign(op1).
  - DONE then drives `lo_o`=quotient and `hi_o`=remainder, and returns to IDLE on the next edge.
  - Any state other than IDLE with `ALUop_i` ≠ DIV (flush): return to IDLE and discard the result.
- `stallReq_o` = (`ALUop_i`==DIV) and (state ≠ DONE). It is combinational.
- −2^31 / −1 (signed) gives quotient 32'h80000000 and remainder 0. No trap.
- ID/EX holds its outputs while `stall[2]` and `stall[3]` are both set, so EX operands stay stable for the whole division.

## Timing
- All non-DIV operations: result valid in the same cycle they are presented; `stallReq_o`=0.
- DIV, nonzero divisor:
  - cycle 0 (IDLE), cycles 1–32 (BUSY), cycle 33 (DONE).
  - `stallReq_o`=1 in cycles 0–32 (33 cycles).
  - `hi_o`/`lo_o` valid in cycle 33 and captured by EX/MEM at the end of cycle 33.
- DIV by zero: `stallReq_o`=1 in cycle 0; result valid in cycle 1.
- Back-to-back DIVs: the second DIV sees IDLE on the cycle after DONE and takes the full 34 cycles.
- `rst` during BUSY: IDLE and `stallReq_o`=0 at the next edge. Partial state is discarded.

## Configuration
- `EX_DIV_EN` defined: the divider FSM and `ex_divider` are instantiated, with behaviour as above.
- `EX_DIV_EN` undefined:
  - ALU_DIV yields `hi_o`=`lo_o`=0 combinationally;
  - `stallReq_o` is tied to 0;
  - no divider logic is built.

## Structure
- `defines.v` holds:
  - `ALU_*` codes (including ALU_DIV, ALU_MULT, ALU_MFHI, ALU_MFLO);
  - divider state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`;
  - `DIV_ITER` = 32.
- Sub-module `ex_divider`:
  - inputs: `clk`, `rst`, `start`, `signed_i`, `dividend`, `divisor`, `cancel`;
  - outputs: `quotient`, `remainder`, `ready`.
- `ex_stage` keeps the combinational ALU, the multiplier and the stall logic.

## Test plan
- ADD 32'h7FFFFFFF + 1 → `writeData_o`=32'h80000000, `stallReq_o`=0.
- SRA with `oprand1_i`=4, `oprand2_i`=32'hF0000000 → 32'hFF000000.
- Signed SLT −1 vs 1 → 1. Unsigned SLT −1 vs 1 → 0.
- Signed MULT −3 × 5 → `hi_o`=32'hFFFFFFFF, `lo_o`=32'hFFFFFFF1, no stall.
- Signed DIV −7 / 2, with inputs held:
  - `stallReq_o` high for exactly 33 cycles;
  - cycle 33: `lo_o`=32'hFFFFFFFD, `hi_o`=32'hFFFFFFFF.
- Unsigned DIV 100 / 7 → `lo_o`=14, `hi_o`=2 in cycle 33.
- DIV 9 / 0 → one stall cycle, then `lo_o`=32'hFFFFFFFF, `hi_o`=9.
- `rst` asserted in BUSY cycle 10:
  - `stallReq_o`=0 the next cycle;
  - a following DIV 100 / 7 again takes 34 cycles and yields 14 remainder 2.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the MIPS32 execute stage.
//   - alu_op_e    : ALU operation codes carried on ALUop_i.
//   - div_state_e : sequential divider states.
//   - DIV_ITER    : number of shift-subtract steps per division.
//   - abs_mag()   : operand magnitude, two's-complement aware.
package ex_stage_pkg;

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_NOR  = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SRA  = 5'd9,
        ALU_SLT  = 5'd10,
        ALU_MULT = 5'd11,
        ALU_DIV  = 5'd12,
        ALU_MFHI = 5'd13,
        ALU_MFLO = 5'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_ITER = 32;

    // Magnitude of v; only negated when signed semantics are requested.
    function automatic logic [31:0] abs_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_divider.sv
// ex_divider: 32-iteration restoring divider used by the execute stage.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : DIV requested; acted on only in DIV_IDLE
//   signed_i   : signed semantics for operand magnitudes and result signs
//   dividend   : operand 1
//   divisor    : operand 2
//   cancel     : operation left the stage; abandon any division in flight
//   quotient   : signed-corrected quotient, valid while ready
//   remainder  : signed-corrected remainder, valid while ready
//   ready      : result available (state DIV_DONE)
module ex_divider
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_i,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        ready
);

    localparam logic [4:0] LastIter = 5'(DIV_ITER - 1);

    div_state_e  state_q;
    logic [31:0] dvd_q;      // dividend shifts out MSB-first, quotient bits shift in
    logic [31:0] dsr_q;
    logic [31:0] rem_q;
    logic [4:0]  cnt_q;
    logic        neg_quot_q;
    logic        neg_rem_q;

    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;

    // Partial remainder is always < divisor, so the shifted value needs 33 bits.
    always_comb begin
        trial = {rem_q, dvd_q[31]};
        diff  = trial - {1'b0, dsr_q};
        fits  = (trial >= {1'b0, dsr_q});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (divisor == 32'd0) begin
                            // Divide by zero: fixed result, no sign correction.
                            dvd_q      <= '1;
                            rem_q      <= dividend;
                            neg_quot_q <= 1'b0;
                            neg_rem_q  <= 1'b0;
                            state_q    <= DIV_DONE;
                        end else begin
                            dvd_q      <= abs_mag(dividend, signed_i);
                            dsr_q      <= abs_mag(divisor, signed_i);
                            rem_q      <= '0;
                            neg_quot_q <= signed_i & (dividend[31] ^ divisor[31]);
                            neg_rem_q  <= signed_i & dividend[31];
                            state_q    <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (cancel) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= fits ? diff[31:0] : trial[31:0];
                        dvd_q <= {dvd_q[30:0], fits};
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == LastIter) begin
                            state_q <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    state_q <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == DIV_DONE);
    assign quotient  = neg_quot_q ? (~dvd_q + 32'd1) : dvd_q;
    assign remainder = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage.
// Combinational ALU (add/sub, logic, shifts, SLT, MFHI/MFLO), 32x32->64 multiplier,
// HI/LO result muxing, write-control pass-through and the EX stall request.
// Optional divider: define EX_DIV_EN to build ex_divider; otherwise DIV yields
// HI/LO = 0 and the stall request is tied low.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ALUop_i                       : operation code (alu_op_e)
//   oprand1_i, oprand2_i          : operands; oprand1_i[4:0] is the shift amount
//   signed_i                      : signed semantics for SLT/MULT/DIV
//   writeAddr_i/writeEnable_i/writeHILO_i -> *_o : pass-through write controls
//   hi_i, lo_i                    : current HI/LO
//   writeData_o                   : GPR result
//   hi_o, lo_o                    : HI/LO result (MULT/DIV only)
//   stallReq_o                    : stall request while a division is pending
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ALUop_i,
    input  logic [31:0] oprand1_i,
    input  logic [31:0] oprand2_i,
    input  logic        signed_i,
    input  logic [4:0]  writeAddr_i,
    input  logic        writeEnable_i,
    input  logic [1:0]  writeHILO_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] writeData_o,
    output logic [4:0]  writeAddr_o,
    output logic        writeEnable_o,
    output logic [1:0]  writeHILO_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallReq_o
);

    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;
    logic        is_div;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_stall;

    assign shamt  = oprand1_i[4:0];
    assign is_div = (ALUop_i == ALU_DIV);

    // Extending to 64 bits first makes one truncated multiply serve both signednesses.
    assign mul_a    = signed_i ? {{32{oprand1_i[31]}}, oprand1_i} : {32'd0, oprand1_i};
    assign mul_b    = signed_i ? {{32{oprand2_i[31]}}, oprand2_i} : {32'd0, oprand2_i};
    assign mul_prod = mul_a * mul_b;

    always_comb begin
        alu_res = '0;
        case (ALUop_i)
            ALU_ADD:  alu_res = oprand1_i + oprand2_i;
            ALU_SUB:  alu_res = oprand1_i - oprand2_i;
            ALU_AND:  alu_res = oprand1_i & oprand2_i;
            ALU_OR:   alu_res = oprand1_i | oprand2_i;
            ALU_XOR:  alu_res = oprand1_i ^ oprand2_i;
            ALU_NOR:  alu_res = ~(oprand1_i | oprand2_i);
            ALU_SLL:  alu_res = oprand2_i << shamt;
            ALU_SRL:  alu_res = oprand2_i >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(oprand2_i) >>> shamt);
            ALU_SLT: begin
                if (signed_i) begin
                    alu_res = {31'd0, $signed(oprand1_i) < $signed(oprand2_i)};
                end else begin
                    alu_res = {31'd0, oprand1_i < oprand2_i};
                end
            end
            ALU_MFHI: alu_res = hi_i;
            ALU_MFLO: alu_res = lo_i;
            default:  alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    logic        div_ready;
    logic        div_cancel;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    assign div_cancel = ~is_div;

    ex_divider u_ex_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .signed_i  (signed_i),
        .dividend  (oprand1_i),
        .divisor   (oprand2_i),
        .cancel    (div_cancel),
        .quotient  (div_quot),
        .remainder (div_rem),
        .ready     (div_ready)
    );

    assign div_stall = is_div & ~div_ready;
    assign div_hi    = div_ready ? div_rem : '0;
    assign div_lo    = div_ready ? div_quot : '0;
`else
    assign div_stall = 1'b0;
    assign div_hi    = '0;
    assign div_lo    = '0;
`endif

    always_comb begin
        writeData_o   = '0;
        writeAddr_o   = '0;
        writeEnable_o = 1'b0;
        writeHILO_o   = '0;
        hi_o          = '0;
        lo_o          = '0;
        stallReq_o    = 1'b0;
        if (!rst) begin
            writeData_o   = alu_res;
            writeAddr_o   = writeAddr_i;
            writeEnable_o = writeEnable_i;
            writeHILO_o   = writeHILO_i;
            stallReq_o    = div_stall;
            if (ALUop_i == ALU_MULT) begin
                {hi_o, lo_o} = mul_prod;
            end else if (is_div) begin
                hi_o = div_hi;
                lo_o = div_lo;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed + randomized checks of ex_stage against an arithmetic
// reference model. Division checks are built only when EX_DIV_EN is defined.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alu_op;
    logic [31:0] op1, op2;
    logic        sgn;
    logic [4:0]  waddr;
    logic        wen;
    logic [1:0]  whilo;
    logic [31:0] hi_in, lo_in;
    logic [31:0] wdata_out;
    logic [4:0]  waddr_out;
    logic        wen_out;
    logic [1:0]  whilo_out;
    logic [31:0] hi_out, lo_out;
    logic        stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ALUop_i       (alu_op),
        .oprand1_i     (op1),
        .oprand2_i     (op2),
        .signed_i      (sgn),
        .writeAddr_i   (waddr),
        .writeEnable_i (wen),
        .writeHILO_i   (whilo),
        .hi_i          (hi_in),
        .lo_i          (lo_in),
        .writeData_o   (wdata_out),
        .writeAddr_o   (waddr_out),
        .writeEnable_o (wen_out),
        .writeHILO_o   (whilo_out),
        .hi_o          (hi_out),
        .lo_o          (lo_out),
        .stallReq_o    (stall_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint pow2(input int sh);
        longint p = 1;
        for (int i = 0; i < sh; i++) p = p * 2;
        return p;
    endfunction

    function automatic longint as_int(input logic [31:0] v, input logic sg);
        return sg ? longint'($signed(v)) : longint'({32'd0, v});
    endfunction

    // GPR result computed with plain arithmetic on 64-bit integers.
    function automatic logic [31:0] ref_gpr(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic sg,
                                            input logic [31:0] hi, input logic [31:0] lo);
        longint p, v, q;
        p = pow2(int'(a[4:0]));
        case (op)
            ALU_ADD:  return 32'(as_int(a, 1'b0) + as_int(b, 1'b0));
            ALU_SUB:  return 32'(as_int(a, 1'b0) - as_int(b, 1'b0));
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLL:  return 32'(as_int(b, 1'b0) * p);
            ALU_SRL:  return 32'(as_int(b, 1'b0) / p);
            ALU_SRA: begin
                v = as_int(b, 1'b1);
                q = v / p;
                if (v < 0 && q * p != v) q = q - 1;   // floor, not truncate
                return 32'(q);
            end
            ALU_SLT:  return (as_int(a, sg) < as_int(b, sg)) ? 32'd1 : 32'd0;
            ALU_MFHI: return hi;
            ALU_MFLO: return lo;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                             input logic sg);
        return 64'(as_int(a, sg) * as_int(b, sg));
    endfunction

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else begin
            q = 32'(as_int(a, sg) / as_int(b, sg));
            r = 32'(as_int(a, sg) % as_int(b, sg));
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sg);
        @(posedge clk);
        #1;
        alu_op = op;
        op1    = a;
        op2    = b;
        sgn    = sg;
        waddr  = 5'($urandom);
        wen    = 1'($urandom);
        whilo  = 2'($urandom);
        hi_in  = $urandom;
        lo_in  = $urandom;
    endtask

    // Counts stall cycles from the current cycle, then checks the DIV result.
    task automatic run_div(input string tag, input int exp_stalls);
        int          cnt = 0;
        logic [31:0] q, r;
        ref_div(op1, op2, sgn, q, r);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_out !== 1'b1) break;
            cnt++;
        end
        check({tag, " stall cycles"}, 32'(cnt), 32'(exp_stalls));
        check({tag, " lo"}, lo_out, q);
        check({tag, " hi"}, hi_out, r);
    endtask

    logic [4:0]  rand_ops [13];
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [63:0] prod;

    initial begin
        rand_ops = '{ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
                     ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_MULT, ALU_MFHI};
        rst = 1'b1;
        alu_op = ALU_NOP; op1 = '0; op2 = '0; sgn = 1'b0;
        waddr = '0; wen = 1'b0; whilo = '0; hi_in = '0; lo_in = '0;

        // Reset: outputs forced to zero regardless of inputs.
        drive(ALU_ADD, 32'h1234, 32'h1, 1'b0);
        waddr = 5'd7; wen = 1'b1; whilo = 2'b11;
        @(negedge clk);
        check("reset writeData", wdata_out, 32'd0);
        check("reset writeAddr", 32'(waddr_out), 32'd0);
        check("reset writeEnable", 32'(wen_out), 32'd0);
        check("reset writeHILO", 32'(whilo_out), 32'd0);
`ifdef EX_DIV_EN
        drive(ALU_DIV, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        check("reset div stall", 32'(stall_out), 32'd0);
`endif
        drive(ALU_MULT, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        check("reset lo", lo_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases.
        drive(ALU_ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
        @(negedge clk);
        check("add wrap", wdata_out, 32'h80000000);
        check("add stall", 32'(stall_out), 32'd0);
        check("passthru addr", 32'(waddr_out), 32'(waddr));
        check("passthru hilo", 32'(whilo_out), 32'(whilo));
        drive(ALU_SRA, 32'd4, 32'hF0000000, 1'b0);
        @(negedge clk);
        check("sra", wdata_out, 32'hFF000000);
        drive(ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b1);
        @(negedge clk);
        check("slt signed", wdata_out, 32'd1);
        drive(ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b0);
        @(negedge clk);
        check("slt unsigned", wdata_out, 32'd0);
        drive(ALU_MULT, 32'hFFFFFFFD, 32'd5, 1'b1);
        @(negedge clk);
        check("mult hi", hi_out, 32'hFFFFFFFF);
        check("mult lo", lo_out, 32'hFFFFFFF1);
        check("mult stall", 32'(stall_out), 32'd0);
        drive(ALU_MFHI, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("mfhi", wdata_out, hi_in);

        // Randomized combinational operations against the model.
        for (int i = 0; i < 60; i++) begin
            op = rand_ops[$urandom_range(0, 12)];
            a  = (i % 7 == 0) ? 32'h80000000 : $urandom;
            b  = (i % 5 == 0) ? 32'hFFFFFFFF : $urandom;
            drive(op, a, b, 1'($urandom));
            @(negedge clk);
            prod = (op == ALU_MULT) ? ref_mult(a, b, sgn) : 64'd0;
            if (op != ALU_MULT) begin
                check("rand gpr", wdata_out, ref_gpr(op, a, b, sgn, hi_in, lo_in));
            end
            if (op != ALU_MFHI) begin
                check("rand hi", hi_out, prod[63:32]);
                check("rand lo", lo_out, prod[31:0]);
            end
            check("rand stall", 32'(stall_out), 32'd0);
            check("rand wen", 32'(wen_out), 32'(wen));
        end

`ifdef EX_DIV_EN
        drive(ALU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        run_div("div -7/2", 33);
        // Inputs held: the next DIV restarts from IDLE and takes the full latency.
        run_div("div back2back", 33);
        drive(ALU_DIV, 32'd100, 32'd7, 1'b0);
        run_div("div 100/7", 33);
        drive(ALU_DIV, 32'd9, 32'd0, 1'b0);
        run_div("div by zero", 1);
        drive(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_div("div min/-1", 33);
        for (int i = 0; i < 4; i++) begin
            drive(ALU_DIV, $urandom, $urandom_range(1, 32'hFFFF) << $urandom_range(0, 16),
                  1'($urandom));
            run_div("div rand", 33);
        end

        // Reset in the middle of a division.
        drive(ALU_DIV, 32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst    = 1'b1;
        alu_op = ALU_NOP;
        @(negedge clk);
        check("rst busy stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after rst stall", 32'(stall_out), 32'd0);
        drive(ALU_DIV, 32'd100, 32'd7, 1'b0);
        run_div("div after rst", 33);
        drive(ALU_NOP, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("nop after div", wdata_out, 32'd0);
`else
        drive(ALU_DIV, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        check("div off stall", 32'(stall_out), 32'd0);
        check("div off hi", hi_out, 32'd0);
        check("div off lo", lo_out, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
